// File: rtl/caliptra_apb_req_driver.sv
// Single-outstanding APB requester: turns one valid/ready request into an APB setup/access
// transfer and returns read data and error status. Optional access timeout: CALIPTRA_APB_DRV_TIMEOUT_EN.
`ifndef CALIPTRA_APB_ADDR_WIDTH
`define CALIPTRA_APB_ADDR_WIDTH 32
`endif
`ifndef CALIPTRA_APB_DATA_WIDTH
`define CALIPTRA_APB_DATA_WIDTH 32
`endif
`ifndef CALIPTRA_APB_USER_WIDTH
`define CALIPTRA_APB_USER_WIDTH 32
`endif

module caliptra_apb_req_driver #(
    parameter int ADDR_W         = `CALIPTRA_APB_ADDR_WIDTH,
    parameter int DATA_W         = `CALIPTRA_APB_DATA_WIDTH,
    parameter int USER_W         = `CALIPTRA_APB_USER_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [USER_W-1:0] req_user,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic [USER_W-1:0] pauser,
    output logic [2:0]        pprot,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr,
    output logic              busy
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..65535");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state_q,     state_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;
    logic                psel_q,      psel_d;
    logic                penable_q,   penable_d;
    logic                pwrite_q,    pwrite_d;
    logic                write_q,     write_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [USER_W-1:0]   user_q,      user_d;
    logic                busy_q,      busy_d;

`ifdef CALIPTRA_APB_DRV_TIMEOUT_EN
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]         wait_cnt_q,  wait_cnt_d;
    logic                rsp_timeout_q, rsp_timeout_d;
`endif

    always_comb begin
        // NOTE: every _d starts as its _q so a branch that skips a signal cannot infer a latch.
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        user_d      = user_q;
        busy_d      = busy_q;
`ifdef CALIPTRA_APB_DRV_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d     = SETUP;
                    write_d     = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    user_d      = req_user;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    psel_d      = 1'b1;
                    pwrite_d    = req_write;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef CALIPTRA_APB_DRV_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ACCESS: begin
                if (pready) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = write_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    pwrite_d    = 1'b0;
`ifdef CALIPTRA_APB_DRV_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    // This is the TIMEOUT_CYCLES-th cycle without pready: abandon the transfer.
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    pwrite_d      = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            user_q      <= '0;
            busy_q      <= 1'b0;
`ifdef CALIPTRA_APB_DRV_TIMEOUT_EN
            wait_cnt_q    <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            user_q      <= user_d;
            busy_q      <= busy_d;
`ifdef CALIPTRA_APB_DRV_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign paddr     = addr_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = wdata_q;
    assign pauser    = user_q;
    assign pprot     = 3'b000;
    assign busy      = busy_q;
`ifdef CALIPTRA_APB_DRV_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_caliptra_apb_req_driver.sv
// Directed bench for caliptra_apb_req_driver; the timeout scenario follows CALIPTRA_APB_DRV_TIMEOUT_EN.
module tb_caliptra_apb_req_driver;

    logic        core_clk;
    logic        core_rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_user;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] pauser;
    logic [2:0]  pprot;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    caliptra_apb_req_driver #(
        .ADDR_W(32), .DATA_W(32), .USER_W(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_user(req_user),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pauser(pauser), .pprot(pprot),
        .pready(pready), .prdata(prdata), .pslverr(pslverr), .busy(busy)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    // Offer one request for exactly one edge, then scramble the request inputs.
    task automatic accept(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] user);
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_user  = user;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 32'h5555_AAAA;
        req_wdata = 32'h0F0F_0F0F;
        req_user  = 32'h1234_0000;
    endtask

    initial begin
        int rsp_cnt;
        core_rst  = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_user  = '0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;

        // Reset state
        #3;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_pauser", pauser, 0);
        check("rst_pprot", pprot, 0);
        check("rst_busy", busy, 0);
        @(posedge core_clk);
        #1;
        core_rst = 1'b0;
        step();

        // Zero-wait write
        pready = 1'b1;
        accept(1'b1, 32'h3003_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        check("w_setup_psel", psel, 1);
        check("w_setup_penable", penable, 0);
        check("w_setup_pwrite", pwrite, 1);
        check("w_setup_paddr", paddr, 32'h3003_0000);
        check("w_setup_pwdata", pwdata, 32'hDEAD_BEEF);
        check("w_setup_pauser", pauser, 32'hFFFF_FFFF);
        check("w_setup_req_ready", req_ready, 0);
        check("w_setup_busy", busy, 1);
        step();
        check("w_access_psel", psel, 1);
        check("w_access_penable", penable, 1);
        check("w_access_paddr", paddr, 32'h3003_0000);
        check("w_access_rsp_valid", rsp_valid, 0);
        step();
        check("w_resp_rsp_valid", rsp_valid, 1);
        check("w_resp_psel", psel, 0);
        check("w_resp_penable", penable, 0);
        check("w_resp_pwrite", pwrite, 0);
        check("w_resp_rdata", rsp_rdata, 0);
        check("w_resp_err", rsp_err, 0);
        check("w_resp_timeout", rsp_timeout, 0);
        check("w_resp_pprot", pprot, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("w_idle_rsp_valid", rsp_valid, 0);
        check("w_idle_req_ready", req_ready, 1);
        check("w_idle_busy", busy, 0);

        // Read with three wait states
        pready = 1'b0;
        prdata = 32'hFFFF_0000;
        accept(1'b0, 32'h3003_0040, 32'h0, 32'h0000_0001);
        check("r_setup_pwrite", pwrite, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("r_access_penable", penable, 1);
            check("r_access_paddr", paddr, 32'h3003_0040);
            check("r_access_rsp_valid", rsp_valid, 0);
            if (k == 4) begin
                pready = 1'b1;
                prdata = 32'h1234_5678;
            end
        end
        step();
        check("r_resp_valid", rsp_valid, 1);
        check("r_resp_rdata", rsp_rdata, 32'h1234_5678);
        check("r_resp_err", rsp_err, 0);
        pready    = 1'b0;
        prdata    = 32'h0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("r_idle_rsp_valid", rsp_valid, 0);

        // Slave error with response backpressure
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hCAFE_F00D;
        accept(1'b0, 32'h3003_0080, 32'h0, 32'h0);
        step();
        step();
        pslverr = 1'b0;
        prdata  = 32'h0;
        for (int j = 0; j < 5; j++) begin
            check("e_resp_valid", rsp_valid, 1);
            check("e_resp_err", rsp_err, 1);
            check("e_resp_rdata", rsp_rdata, 32'hCAFE_F00D);
            check("e_resp_req_ready", req_ready, 0);
            check("e_resp_psel", psel, 0);
            if (j == 4) rsp_ready = 1'b1;
            step();
        end
        check("e_after_rsp_valid", rsp_valid, 0);
        check("e_after_req_ready", req_ready, 1);

        // Eight back-to-back writes, four cycles each
        rsp_cnt   = 0;
        req_write = 1'b1;
        req_addr  = 32'h3003_0100;
        req_user  = 32'h0;
        req_wdata = 32'h1000_0000;
        req_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            check("b2b_psel", psel, ((i % 4) < 2) ? 1 : 0);
            check("b2b_penable", penable, ((i % 4) == 1) ? 1 : 0);
            check("b2b_rsp_valid", rsp_valid, ((i % 4) == 2) ? 1 : 0);
            if ((i % 4) == 0) check("b2b_pwdata", pwdata, 32'h1000_0000 + 32'(i / 4));
            if (rsp_valid) rsp_cnt++;
            if ((i % 4) == 3) req_wdata = 32'h1000_0000 + 32'(i / 4) + 32'd1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("b2b_rsp_count", rsp_cnt, 8);

        // Long ACCESS wait
        pready = 1'b0;
        prdata = 32'h0000_0077;
`ifdef CALIPTRA_APB_DRV_TIMEOUT_EN
        accept(1'b0, 32'h3003_0100, 32'h0, 32'h0);
        step();
        for (int k = 2; k <= 16; k++) begin
            step();
            check("to_wait_psel", psel, 1);
            check("to_wait_rsp_valid", rsp_valid, 0);
        end
        step();
        check("to_psel", psel, 0);
        check("to_penable", penable, 0);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_timeout", rsp_timeout, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        accept(1'b0, 32'h3003_0104, 32'h0, 32'h0);
        step();
        for (int k = 2; k <= 16; k++) step();
        pready = 1'b1;
        prdata = 32'h600D_CAFE;
        step();
        check("lim_rsp_valid", rsp_valid, 1);
        check("lim_rsp_err", rsp_err, 0);
        check("lim_rsp_timeout", rsp_timeout, 0);
        check("lim_rsp_rdata", rsp_rdata, 32'h600D_CAFE);
`else
        accept(1'b0, 32'h3003_0100, 32'h0, 32'h0);
        step();
        for (int k = 2; k <= 40; k++) begin
            step();
            check("wait_psel", psel, 1);
            check("wait_penable", penable, 1);
            check("wait_rsp_valid", rsp_valid, 0);
        end
        pready = 1'b1;
        prdata = 32'h0BAD_F00D;
        step();
        check("wait_rsp_valid_end", rsp_valid, 1);
        check("wait_rsp_timeout", rsp_timeout, 0);
        check("wait_rsp_err", rsp_err, 0);
        check("wait_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
`endif
        pready    = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset in the middle of ACCESS
        accept(1'b1, 32'h3003_0200, 32'h0000_00AA, 32'h0);
        step();
        check("mr_access_penable", penable, 1);
        #2;
        core_rst = 1'b1;
        #1;
        check("mr_psel", psel, 0);
        check("mr_penable", penable, 0);
        check("mr_rsp_valid", rsp_valid, 0);
        check("mr_req_ready", req_ready, 1);
        check("mr_busy", busy, 0);
        @(posedge core_clk);
        #1;
        core_rst = 1'b0;
        step();
        check("mr_after_rsp_valid", rsp_valid, 0);
        check("mr_after_psel", psel, 0);
        pready = 1'b1;
        prdata = 32'hA5A5_5A5A;
        accept(1'b0, 32'h3003_0204, 32'h0, 32'h0);
        check("mr_next_psel", psel, 1);
        check("mr_next_paddr", paddr, 32'h3003_0204);
        step();
        step();
        check("mr_next_rsp_valid", rsp_valid, 1);
        check("mr_next_rdata", rsp_rdata, 32'hA5A5_5A5A);
        check("mr_next_err", rsp_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
